// File: rtl/switch_key_in.sv
// switch_key_in: synchronised, debounced DIP-switch / push-key input peripheral with key-event interrupt.
// Optional macro KEY_RELEASE_EVENT_EN adds release events in PEND/MASK[2*KEY_W-1:KEY_W] (needs KEY_W <= 16).
module switch_key_in #(
  parameter int TICK_DIV = 50000,
  parameter int KEY_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [31:0]      in,
  output logic [31:0]      out,
  input  logic [31:0]      sw_in,
  input  logic [KEY_W-1:0] key_in,
  output logic             irq
);
  localparam int N  = 32 + KEY_W;
`ifdef KEY_RELEASE_EVENT_EN
  localparam int PW = 2 * KEY_W;
`else
  localparam int PW = KEY_W;
`endif
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N-1:0]        sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0][N-1:0]   hist_q, hist_d;
  logic [N-1:0]        deb_q, deb_d;
  logic [PW-1:0]       pend_q, pend_d, mask_q, mask_d;
  logic                irq_q, irq_d;
  logic                tick;
  logic [N-1:0]        stable;
  logic [KEY_W-1:0]    key_rise, key_fall;
  logic [PW-1:0]       ev;

  // A bit is stable when the three most recent tick samples agree.
  for (genvar gi = 0; gi < N; gi++) begin : g_stable
    assign stable[gi] = (hist_d[0][gi] == hist_d[1][gi]) && (hist_d[1][gi] == hist_d[2][gi]);
  end

  if (PW < 32) begin : g_unused_in
    logic unused_in;
    assign unused_in = ^in[31:PW];
  end

  always_comb begin
    tick    = (cnt_q == CW'(TICK_DIV - 1));
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    sync1_d = {key_in, sw_in};
    sync2_d = sync1_q;
    hist_d  = hist_q;
    deb_d   = deb_q;
    if (tick) begin
      hist_d = {hist_q[1:0], sync2_q};
      deb_d  = (deb_q & ~stable) | (hist_d[0] & stable);
    end
  end

  always_comb begin
    key_rise = deb_d[N-1:32] & ~deb_q[N-1:32];
    key_fall = deb_q[N-1:32] & ~deb_d[N-1:32];
`ifdef KEY_RELEASE_EVENT_EN
    ev = {key_fall, key_rise};
`else
    ev = key_rise;
`endif
    pend_d = pend_q;
    mask_d = mask_q;
    if (we && addr == 2'd2) pend_d = pend_q & ~in[PW-1:0];
    if (we && addr == 2'd3) mask_d = in[PW-1:0];
    // A fresh event overrides a simultaneous write-1-to-clear.
    pend_d = pend_d | ev;
    irq_d  = |(pend_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      deb_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      deb_q   <= deb_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    out = '0;
    case (addr)
      2'd0:    out = deb_q[31:0];
      2'd1:    out[KEY_W-1:0] = deb_q[N-1:32];
      2'd2:    out[PW-1:0] = pend_q;
      default: out[PW-1:0] = mask_q;
    endcase
  end

  assign irq = irq_q;

  // Release events only exist when the macro is defined.
`ifndef KEY_RELEASE_EVENT_EN
  logic unused_fall;
  assign unused_fall = ^key_fall;
`endif

endmodule

// File: doc/switch_key_in.md
Name: switch_key_in

Overview:
- CPU-readable input peripheral; the read-direction counterpart of the LED/digit output device on the same bridge bus.
- Synchronises and debounces 32 DIP switches and 8 push keys, exposes levels, latches key-press events and raises an interrupt request to the CP0/bridge.
- Uses the same bus shape as the output device: word register select `addr`, `we`, `in`, and combinational `out`.

Parameters:
- TICK_DIV, 50000, clock cycles between debounce samples (≥2)
- KEY_W, 8, number of push keys (1..32)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- addr  in  2  register select (word index)
- we  in  1  write enable
- in  in  32  write data
- out  out  32  read data, combinational on addr
- sw_in  in  32  raw switch pins, asynchronous
- key_in  in  KEY_W  raw key pins, asynchronous, 1 = pressed
- irq  out  1  interrupt request, level

Behaviour:
- Sync: every raw bit passes through a 2-FF synchroniser on clk.
- Tick: counter 0..TICK_DIV-1 wraps; `tick` asserts one cycle when count == TICK_DIV-1.
- On tick, each synchronised bit shifts into a 3-sample history.
- Debounced bit updates to the sample only when all 3 history samples are equal; otherwise it holds.
- Worst-case latency, stable pin change to debounced change: 2 + 3·TICK_DIV cycles.
- Press event: debounced key bit goes 0→1 → pend[i] set on the same cycle the debounced value updates.
- Register map, read:
  - 0: SW = debounced switches
  - 1: KEY = zero-extended debounced keys
  - 2: PEND = zero-extended pending events
  - 3: MASK = zero-extended interrupt mask
- Register map, write:
  - 0, 1: ignored, no side effect.
  - 2: write-1-to-clear; pend[i] cleared where in[i] = 1.
  - 3: mask <= in[KEY_W-1:0].
- Bits above KEY_W: write ignored, read 0.
- Simultaneous W1C and new event on the same bit: event wins, bit stays 1.
- irq = |(pend & mask), registered: asserts the cycle after pend or mask changes.
- Reset: tick counter, histories, debounced values, pend, mask, irq all 0, so `out` reads 0 at every addr. Synchroniser flops also 0.
- Reset mid-bounce discards history; debouncing restarts from all-zero.
- Asserting a mask bit while its pend bit is already 1 raises irq next cycle; pending events are not lost by masking.

Optional Feature:
- Macro: KEY_RELEASE_EVENT_EN
- Defined:
  - PEND widens to 2·KEY_W bits: [KEY_W-1:0] = press events, [2·KEY_W-1:KEY_W] = release events (debounced 1→0).
  - MASK widens to match; W1C and mask writes cover all 2·KEY_W bits.
  - Requires KEY_W ≤ 16.
- Undefined: release edges produce no event; upper bits read 0.

Test Plan:
- Reset for 2 cycles with random pins → `out` = 0 at addr 0..3; irq = 0.
- TICK_DIV=4: set sw_in = 32'hA5A5_0F0F stable → addr 0 reads 32'hA5A5_0F0F within 14 cycles, 0 before 6 cycles.
- TICK_DIV=4: key_in[2] toggling every 3 cycles for 40 cycles, then held 1 → KEY stays 0 during bounce, then reads 32'h4; PEND = 32'h4 exactly once.
- mask = 32'h4, then key 2 press → irq rises 1 cycle after pend[2]; write 32'h4 to addr 2 → pend clears, irq falls next cycle.
- W1C on addr 2 issued in the same cycle a new key-0 press is detected → pend[0] remains 1.
- With KEY_RELEASE_EVENT_EN: press then release key 1 → PEND = 32'h0202; write 0 to addr 0 → SW unchanged.
